// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory stage: FSM states, load/store
// size encodings and the byte-strobe width.
package mem_stage_pkg;
    localparam int DATA_WIDTH_DEF = 64;
    localparam int STRB_WIDTH     = DATA_WIDTH_DEF / 8;

    typedef enum logic {
        IDLE,
        WAIT_RESP
    } state_t;

    localparam logic [2:0] LB  = 3'd0;
    localparam logic [2:0] LH  = 3'd1;
    localparam logic [2:0] LW  = 3'd2;
    localparam logic [2:0] LD  = 3'd3;
    localparam logic [2:0] LBU = 3'd4;
    localparam logic [2:0] LHU = 3'd5;
    localparam logic [2:0] LWU = 3'd6;

    localparam logic [2:0] SB  = 3'd0;
    localparam logic [2:0] SH  = 3'd1;
    localparam logic [2:0] SW  = 3'd2;
    localparam logic [2:0] SD  = 3'd3;
endpackage

// File: rtl/load_store_align.sv
// Combinational lane steering: shifts store data and strobes into their byte
// lanes, and pulls load data down from its lane with sign/zero extension.
module load_store_align
    import mem_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 64
) (
    input  logic [2:0]              i_off,
    input  logic [2:0]              i_func3,
    input  logic [DATA_WIDTH-1:0]   i_write_data,
    input  logic [DATA_WIDTH-1:0]   i_rdata,
    output logic [DATA_WIDTH-1:0]   o_wdata,
    output logic [STRB_WIDTH-1:0]   o_wstrb,
    output logic [DATA_WIDTH-1:0]   o_load_data
);
    logic [STRB_WIDTH-1:0] strb_base;
    logic [DATA_WIDTH-1:0] lane;

    // NOTE: every output gets a default first so no path can infer a latch.
    always_comb begin
        strb_base   = '0;
        o_load_data = '0;

        o_wdata = i_write_data << {i_off, 3'b000};

        case (i_func3[1:0])
            2'd0:    strb_base = 8'h01;
            2'd1:    strb_base = 8'h03;
            2'd2:    strb_base = 8'h0F;
            default: strb_base = 8'hFF;
        endcase
        // Strobe bits shifted past lane 7 fall off: misaligned tails are dropped.
        o_wstrb = strb_base << i_off;

        lane = i_rdata >> {i_off, 3'b000};
        case (i_func3)
            LB:      o_load_data = {{(DATA_WIDTH-8){lane[7]}},   lane[7:0]};
            LH:      o_load_data = {{(DATA_WIDTH-16){lane[15]}}, lane[15:0]};
            LW:      o_load_data = {{(DATA_WIDTH-32){lane[31]}}, lane[31:0]};
            LD:      o_load_data = lane;
            LBU:     o_load_data = {{(DATA_WIDTH-8){1'b0}},  lane[7:0]};
            LHU:     o_load_data = {{(DATA_WIDTH-16){1'b0}}, lane[15:0]};
            LWU:     o_load_data = {{(DATA_WIDTH-32){1'b0}}, lane[31:0]};
            default: o_load_data = '0;
        endcase
    end
endmodule

// File: rtl/preg_memory.sv
// Memory/writeback pipeline register. A bubble kills the register write and
// result select while holding the remaining fields.
module preg_memory #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic                  i_bubble,
    input  logic [ADDR_WIDTH-1:0] i_pc_plus4,
    input  logic [ADDR_WIDTH-1:0] i_pc_target,
    input  logic [DATA_WIDTH-1:0] i_imm_ext,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic [DATA_WIDTH-1:0] i_read_data,
    input  logic [REG_ADDR_W-1:0] i_rd_addr,
    input  logic [2:0]            i_result_src,
    input  logic                  i_reg_we,
    output logic [ADDR_WIDTH-1:0] o_pc_plus4,
    output logic [ADDR_WIDTH-1:0] o_pc_target,
    output logic [DATA_WIDTH-1:0] o_imm_ext,
    output logic [DATA_WIDTH-1:0] o_alu_result,
    output logic [DATA_WIDTH-1:0] o_read_data,
    output logic [REG_ADDR_W-1:0] o_rd_addr,
    output logic [2:0]            o_result_src,
    output logic                  o_reg_we
);
    // NOTE: non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            o_pc_plus4   <= '0;
            o_pc_target  <= '0;
            o_imm_ext    <= '0;
            o_alu_result <= '0;
            o_read_data  <= '0;
            o_rd_addr    <= '0;
            o_result_src <= '0;
            o_reg_we     <= 1'b0;
        end else if (i_bubble) begin
            o_result_src <= '0;
            o_reg_we     <= 1'b0;
        end else begin
            o_pc_plus4   <= i_pc_plus4;
            o_pc_target  <= i_pc_target;
            o_imm_ext    <= i_imm_ext;
            o_alu_result <= i_alu_result;
            o_read_data  <= i_read_data;
            o_rd_addr    <= i_rd_addr;
            o_result_src <= i_result_src;
            o_reg_we     <= i_reg_we;
        end
    end
endmodule

// File: rtl/memory_stage.sv
// Memory pipeline stage: issues data-memory requests, stalls upstream while an
// access is outstanding, and registers results toward writeback.
module memory_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64,
    parameter int REG_ADDR_W = 5
) (
    input  logic                    i_clk,
    input  logic                    i_arst,
    input  logic [ADDR_WIDTH-1:0]   i_pc_plus4,
    input  logic [ADDR_WIDTH-1:0]   i_pc_target,
    input  logic [DATA_WIDTH-1:0]   i_alu_result,
    input  logic [DATA_WIDTH-1:0]   i_write_data,
    input  logic [DATA_WIDTH-1:0]   i_imm_ext,
    input  logic [REG_ADDR_W-1:0]   i_rd_addr,
    input  logic [2:0]              i_result_src,
    input  logic [2:0]              i_func3,
    input  logic                    i_mem_we,
    input  logic                    i_mem_re,
    input  logic                    i_reg_we,
    output logic                    o_dmem_req_valid,
    input  logic                    i_dmem_req_ready,
    output logic [ADDR_WIDTH-1:0]   o_dmem_addr,
    output logic                    o_dmem_we,
    output logic [DATA_WIDTH-1:0]   o_dmem_wdata,
    output logic [STRB_WIDTH-1:0]   o_dmem_wstrb,
    input  logic                    i_dmem_resp_valid,
    input  logic [DATA_WIDTH-1:0]   i_dmem_rdata,
    output logic                    o_stall_mem,
    output logic [REG_ADDR_W-1:0]   o_rd_addr_fwd,
    output logic                    o_reg_we_fwd,
    output logic [ADDR_WIDTH-1:0]   o_pc_plus4,
    output logic [ADDR_WIDTH-1:0]   o_pc_target,
    output logic [DATA_WIDTH-1:0]   o_imm_ext,
    output logic [DATA_WIDTH-1:0]   o_alu_result,
    output logic [DATA_WIDTH-1:0]   o_read_data,
    output logic [REG_ADDR_W-1:0]   o_rd_addr,
    output logic [2:0]              o_result_src,
    output logic                    o_reg_we
);
    state_t                state, state_nx;
    logic                  is_store, is_load, load_done;
    logic [DATA_WIDTH-1:0] load_data, preg_read_data;

    // A set write enable wins when both enables are asserted.
    assign is_store = i_mem_we;
    assign is_load  = i_mem_re & ~i_mem_we;

    assign o_dmem_addr   = ADDR_WIDTH'(i_alu_result);
    assign o_dmem_we     = is_store;
    assign o_rd_addr_fwd = i_rd_addr;
    assign o_reg_we_fwd  = i_reg_we;

    load_store_align #(.DATA_WIDTH(DATA_WIDTH)) u_align (
        .i_off        (i_alu_result[2:0]),
        .i_func3      (i_func3),
        .i_write_data (i_write_data),
        .i_rdata      (i_dmem_rdata),
        .o_wdata      (o_dmem_wdata),
        .o_wstrb      (o_dmem_wstrb),
        .o_load_data  (load_data)
    );

    always_ff @(posedge i_clk) begin
        if (i_arst) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx         = state;
        o_dmem_req_valid = 1'b0;
        o_stall_mem      = 1'b0;
        load_done        = 1'b0;
        case (state)
            IDLE: begin
                if (is_store) begin
                    o_dmem_req_valid = 1'b1;
                    o_stall_mem      = ~i_dmem_req_ready;
                end else if (is_load) begin
                    o_dmem_req_valid = 1'b1;
                    o_stall_mem      = 1'b1;
                    if (i_dmem_req_ready) state_nx = WAIT_RESP;
                end
            end
            WAIT_RESP: begin
                o_stall_mem = ~i_dmem_resp_valid;
                if (i_dmem_resp_valid) begin
                    load_done = 1'b1;
                    state_nx  = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign preg_read_data = load_done ? load_data : '0;

    preg_memory #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_preg (
        .i_clk        (i_clk),
        .i_arst       (i_arst),
        .i_bubble     (o_stall_mem),
        .i_pc_plus4   (i_pc_plus4),
        .i_pc_target  (i_pc_target),
        .i_imm_ext    (i_imm_ext),
        .i_alu_result (i_alu_result),
        .i_read_data  (preg_read_data),
        .i_rd_addr    (i_rd_addr),
        .i_result_src (i_result_src),
        .i_reg_we     (i_reg_we),
        .o_pc_plus4   (o_pc_plus4),
        .o_pc_target  (o_pc_target),
        .o_imm_ext    (o_imm_ext),
        .o_alu_result (o_alu_result),
        .o_read_data  (o_read_data),
        .o_rd_addr    (o_rd_addr),
        .o_result_src (o_result_src),
        .o_reg_we     (o_reg_we)
    );
endmodule

// File: tb/tb_memory_stage.sv
// Randomized bench for memory_stage: a transaction-level model predicts the
// per-cycle handshake, stall and pipeline-register behaviour.
module tb_memory_stage;
    logic        clk = 1'b0;
    logic        i_arst;
    logic [63:0] i_pc_plus4, i_pc_target, i_alu_result, i_write_data, i_imm_ext;
    logic [4:0]  i_rd_addr;
    logic [2:0]  i_result_src, i_func3;
    logic        i_mem_we, i_mem_re, i_reg_we;
    logic        o_dmem_req_valid, i_dmem_req_ready;
    logic [63:0] o_dmem_addr;
    logic        o_dmem_we;
    logic [63:0] o_dmem_wdata;
    logic [7:0]  o_dmem_wstrb;
    logic        i_dmem_resp_valid;
    logic [63:0] i_dmem_rdata;
    logic        o_stall_mem;
    logic [4:0]  o_rd_addr_fwd;
    logic        o_reg_we_fwd;
    logic [63:0] o_pc_plus4, o_pc_target, o_imm_ext, o_alu_result, o_read_data;
    logic [4:0]  o_rd_addr;
    logic [2:0]  o_result_src;
    logic        o_reg_we;

    always #5 clk = ~clk;

    memory_stage dut (
        .i_clk(clk), .i_arst(i_arst),
        .i_pc_plus4(i_pc_plus4), .i_pc_target(i_pc_target),
        .i_alu_result(i_alu_result), .i_write_data(i_write_data),
        .i_imm_ext(i_imm_ext), .i_rd_addr(i_rd_addr),
        .i_result_src(i_result_src), .i_func3(i_func3),
        .i_mem_we(i_mem_we), .i_mem_re(i_mem_re), .i_reg_we(i_reg_we),
        .o_dmem_req_valid(o_dmem_req_valid), .i_dmem_req_ready(i_dmem_req_ready),
        .o_dmem_addr(o_dmem_addr), .o_dmem_we(o_dmem_we),
        .o_dmem_wdata(o_dmem_wdata), .o_dmem_wstrb(o_dmem_wstrb),
        .i_dmem_resp_valid(i_dmem_resp_valid), .i_dmem_rdata(i_dmem_rdata),
        .o_stall_mem(o_stall_mem), .o_rd_addr_fwd(o_rd_addr_fwd),
        .o_reg_we_fwd(o_reg_we_fwd),
        .o_pc_plus4(o_pc_plus4), .o_pc_target(o_pc_target),
        .o_imm_ext(o_imm_ext), .o_alu_result(o_alu_result),
        .o_read_data(o_read_data), .o_rd_addr(o_rd_addr),
        .o_result_src(o_result_src), .o_reg_we(o_reg_we)
    );

    int n_pass = 0, n_total = 0, stall_cnt = 0;
    bit chk_en = 0;

    // Expected combinational values for the current cycle.
    bit          e_rv, e_stall, e_we;
    logic [63:0] e_addr, e_wdata, e_ld_val;
    logic [7:0]  e_wstrb;
    logic [63:0] last_wdata;
    logic [7:0]  last_wstrb;

    // Expected writeback register contents.
    logic [63:0] r_pc4, r_pct, r_imm, r_alu, r_rdata;
    logic [4:0]  r_rd;
    logic [2:0]  r_rs;
    logic        r_we;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    endtask

    function automatic logic [63:0] m_wdata(input logic [63:0] wd, input int off);
        return wd << (8 * off);
    endfunction

    function automatic logic [7:0] m_wstrb(input logic [2:0] f3, input int off);
        int nbytes = 1 << f3[1:0];
        int bits = ((1 << nbytes) - 1) << off;
        return bits[7:0];
    endfunction

    function automatic logic [63:0] m_load(input logic [63:0] rd, input logic [2:0] f3, input int off);
        logic [63:0] lane = rd >> (8 * off);
        logic [63:0] mask, v;
        int nbits;
        if (f3 == 3'd7) return 64'd0;
        if (f3 == 3'd3) return lane;
        nbits = 8 << f3[1:0];
        mask = (64'd1 << nbits) - 64'd1;
        v = lane & mask;
        if (!f3[2] && ((v >> (nbits - 1)) & 64'd1) == 64'd1) v = v | ~mask;
        return v;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            check("stall", o_stall_mem, e_stall);
            check("req_valid", o_dmem_req_valid, e_rv);
            if (e_rv) begin
                check("dmem_addr", o_dmem_addr, e_addr);
                check("dmem_we", o_dmem_we, e_we);
                if (e_we) begin
                    check("dmem_wdata", o_dmem_wdata, e_wdata);
                    check("dmem_wstrb", o_dmem_wstrb, e_wstrb);
                    last_wdata = o_dmem_wdata;
                    last_wstrb = o_dmem_wstrb;
                end
            end
            check("rd_addr_fwd", o_rd_addr_fwd, i_rd_addr);
            check("reg_we_fwd", o_reg_we_fwd, i_reg_we);
            check("wb_pc_plus4", o_pc_plus4, r_pc4);
            check("wb_pc_target", o_pc_target, r_pct);
            check("wb_imm_ext", o_imm_ext, r_imm);
            check("wb_alu_result", o_alu_result, r_alu);
            check("wb_read_data", o_read_data, r_rdata);
            check("wb_rd_addr", o_rd_addr, r_rd);
            check("wb_result_src", o_result_src, r_rs);
            check("wb_reg_we", o_reg_we, r_we);
            if (o_stall_mem) stall_cnt++;
        end
    end

    task automatic clear_exp_reg();
        r_pc4 = '0; r_pct = '0; r_imm = '0; r_alu = '0; r_rdata = '0;
        r_rd = '0; r_rs = '0; r_we = 1'b0;
    endtask

    // One clock cycle: publish expectations, let the compare run, then
    // advance the writeback model by the same rule the stage must follow.
    task automatic step(input bit rv, input bit st, input bit ld_done);
        e_rv = rv;
        e_stall = st;
        @(negedge clk);
        @(posedge clk);
        #1;
        if (st) begin
            r_we = 1'b0;
            r_rs = '0;
        end else begin
            r_pc4 = i_pc_plus4; r_pct = i_pc_target; r_imm = i_imm_ext;
            r_alu = i_alu_result; r_rd = i_rd_addr; r_rs = i_result_src;
            r_we = i_reg_we;
            r_rdata = ld_done ? e_ld_val : 64'd0;
        end
    endtask

    // kind: 0 ALU op, 1 store, 2 load, 3 both enables (acts as store).
    // rdy_dly cycles of ready low before the handshake; resp_dly >= 1 cycles to response.
    task automatic run_instr(input int kind, input logic [2:0] f3, input logic [63:0] addr,
                             input logic [63:0] wd, input logic [63:0] rdat,
                             input int rdy_dly, input int resp_dly,
                             input logic [4:0] rd, input logic rwe);
        int off = int'(addr[2:0]);
        stall_cnt = 0;
        i_pc_plus4 = {$urandom, $urandom};
        i_pc_target = {$urandom, $urandom};
        i_imm_ext = {$urandom, $urandom};
        i_result_src = 3'($urandom);
        i_alu_result = addr;
        i_write_data = wd;
        i_dmem_rdata = rdat;
        i_func3 = f3;
        i_rd_addr = rd;
        i_reg_we = rwe;
        i_mem_we = (kind == 1 || kind == 3);
        i_mem_re = (kind == 2 || kind == 3);
        e_addr = addr;
        e_we = i_mem_we;
        e_wdata = m_wdata(wd, off);
        e_wstrb = m_wstrb(f3, off);
        e_ld_val = m_load(rdat, f3, off);
        if (kind == 0) begin
            i_dmem_req_ready = 1'($urandom);
            i_dmem_resp_valid = ($urandom_range(3) == 0);
            step(1'b0, 1'b0, 1'b0);
        end else if (kind != 2) begin
            for (int k = 0; k <= rdy_dly; k++) begin
                i_dmem_req_ready = (k == rdy_dly);
                i_dmem_resp_valid = ($urandom_range(3) == 0);
                step(1'b1, k < rdy_dly, 1'b0);
            end
        end else begin
            for (int k = 0; k <= rdy_dly; k++) begin
                i_dmem_req_ready = (k == rdy_dly);
                i_dmem_resp_valid = ($urandom_range(3) == 0);
                step(1'b1, 1'b1, 1'b0);
            end
            for (int j = 1; j <= resp_dly; j++) begin
                i_dmem_req_ready = 1'($urandom);
                i_dmem_resp_valid = (j == resp_dly);
                step(1'b0, j < resp_dly, j == resp_dly);
            end
        end
    endtask

    task automatic check_regs_zero(input string tag);
        check({tag, "_pc_plus4"}, o_pc_plus4, 64'd0);
        check({tag, "_pc_target"}, o_pc_target, 64'd0);
        check({tag, "_imm_ext"}, o_imm_ext, 64'd0);
        check({tag, "_alu_result"}, o_alu_result, 64'd0);
        check({tag, "_read_data"}, o_read_data, 64'd0);
        check({tag, "_rd_addr"}, o_rd_addr, 64'd0);
        check({tag, "_result_src"}, o_result_src, 64'd0);
        check({tag, "_reg_we"}, o_reg_we, 64'd0);
    endtask

    initial begin
        i_arst = 1'b1;
        i_pc_plus4 = '0; i_pc_target = '0; i_alu_result = '0; i_write_data = '0;
        i_imm_ext = '0; i_rd_addr = '0; i_result_src = '0; i_func3 = '0;
        i_mem_we = 1'b0; i_mem_re = 1'b0; i_reg_we = 1'b0;
        i_dmem_req_ready = 1'b0; i_dmem_resp_valid = 1'b0; i_dmem_rdata = '0;
        e_rv = 0; e_stall = 0; e_we = 0; e_addr = '0; e_wdata = '0; e_wstrb = '0;
        e_ld_val = '0; last_wdata = '0; last_wstrb = '0;
        repeat (2) @(posedge clk);
        #1;
        check_regs_zero("reset");
        check("reset_req_valid", o_dmem_req_valid, 64'd0);
        check("reset_stall", o_stall_mem, 64'd0);
        i_arst = 1'b0;
        clear_exp_reg();
        chk_en = 1;

        // Literal pins on the model itself.
        check("model_sb_wdata", m_wdata(64'hAB, 5), 64'h0000_AB00_0000_0000);
        check("model_sb_wstrb", m_wstrb(3'd0, 5), 64'h20);
        check("model_sw_wstrb_misaligned", m_wstrb(3'd2, 6), 64'hC0);
        check("model_lb", m_load(64'h0000_0000_8000_0000, 3'd0, 3), 64'hFFFF_FFFF_FFFF_FF80);
        check("model_lhu", m_load(64'hBEEF_0000_0000_0000, 3'd5, 6), 64'h0000_0000_0000_BEEF);
        check("model_lw", m_load(64'hBEEF_0000_0000_0000, 3'd2, 4), 64'hFFFF_FFFF_BEEF_0000);

        // sb, ready immediately: single cycle, no stall.
        run_instr(1, 3'd0, 64'h1005, 64'hAB, 64'd0, 0, 0, 5'd3, 1'b0);
        check("sb_wdata", last_wdata, 64'h0000_AB00_0000_0000);
        check("sb_wstrb", last_wstrb, 64'h20);
        check("sb_stall_cycles", stall_cnt, 64'd0);

        // sd with ready low for 3 cycles.
        run_instr(1, 3'd3, 64'h3000, 64'h1122_3344_5566_7788, 64'd0, 3, 0, 5'd0, 1'b0);
        check("sd_stall_cycles", stall_cnt, 64'd3);
        check("sd_wdata", last_wdata, 64'h1122_3344_5566_7788);
        check("sd_wstrb", last_wstrb, 64'hFF);

        // lb: one cycle ready wait, response two cycles after handshake.
        run_instr(2, 3'd0, 64'h2003, 64'd0, 64'h0000_0000_8000_0000, 1, 2, 5'd9, 1'b1);
        check("lb_read_data", o_read_data, 64'hFFFF_FFFF_FFFF_FF80);
        check("lb_stall_cycles", stall_cnt, 64'd3);
        check("lb_reg_we", o_reg_we, 64'd1);

        run_instr(2, 3'd5, 64'h2006, 64'd0, 64'hBEEF_0000_0000_0000, 0, 1, 5'd10, 1'b1);
        check("lhu_read_data", o_read_data, 64'h0000_0000_0000_BEEF);
        check("lhu_stall_cycles", stall_cnt, 64'd1);
        run_instr(2, 3'd2, 64'h2004, 64'd0, 64'hBEEF_0000_0000_0000, 0, 1, 5'd11, 1'b1);
        check("lw_read_data", o_read_data, 64'hFFFF_FFFF_BEEF_0000);

        // Plain ALU op.
        run_instr(0, 3'd0, 64'h0000_0000_DEAD_BEEF, 64'd0, 64'd0, 0, 0, 5'd7, 1'b1);
        check("alu_rd_addr", o_rd_addr, 64'd7);
        check("alu_reg_we", o_reg_we, 64'd1);
        check("alu_result", o_alu_result, 64'h0000_0000_DEAD_BEEF);
        check("alu_stall_cycles", stall_cnt, 64'd0);

        // Reset while waiting on a load response; the late response is ignored.
        i_alu_result = 64'h4000; i_func3 = 3'd3; i_mem_re = 1'b1; i_mem_we = 1'b0;
        i_reg_we = 1'b1; i_rd_addr = 5'd4; e_addr = 64'h4000; e_we = 1'b0;
        i_dmem_req_ready = 1'b1; i_dmem_resp_valid = 1'b0;
        step(1'b1, 1'b1, 1'b0);
        chk_en = 0;
        i_arst = 1'b1;
        @(posedge clk);
        #1;
        i_arst = 1'b0;
        i_mem_re = 1'b0;
        i_dmem_resp_valid = 1'b1;
        i_dmem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        #1;
        check_regs_zero("midload_reset");
        check("midload_req_valid", o_dmem_req_valid, 64'd0);
        check("midload_stall", o_stall_mem, 64'd0);
        clear_exp_reg();
        chk_en = 1;
        step(1'b0, 1'b0, 1'b0);
        check("late_resp_read_data", o_read_data, 64'd0);

        // Randomized traffic.
        for (int n = 0; n < 300; n++) begin
            int kind = $urandom_range(3);
            logic [2:0] f3 = (kind == 2) ? 3'($urandom) : 3'($urandom_range(3));
            run_instr(kind, f3, {$urandom, $urandom}, {$urandom, $urandom},
                      {$urandom, $urandom}, $urandom_range(3), 1 + $urandom_range(2),
                      5'($urandom), 1'($urandom));
        end

        chk_en = 0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Pipeline stage directly downstream of the execute stage; consumes its pipeline-register outputs.
- Performs data-memory loads and stores over a valid/ready request plus valid response interface, with variable latency.
- Aligns store data and generates byte strobes; extracts and sign/zero-extends load data.
- Stalls the pipeline while an access is outstanding, then registers results into the memory/writeback pipeline register.

Parameters:
ADDR_WIDTH, 64, byte address width
DATA_WIDTH, 64, data/register width (8 byte lanes)
REG_ADDR_W, 5, register-file index width

Ports:
i_clk  in  1  clock
i_arst  in  1  reset, synchronous, active-high
i_pc_plus4  in  ADDR_WIDTH  from execute
i_pc_target  in  ADDR_WIDTH  from execute
i_alu_result  in  DATA_WIDTH  memory byte address / ALU result
i_write_data  in  DATA_WIDTH  store data (unaligned, LSB-justified)
i_imm_ext  in  DATA_WIDTH  from execute
i_rd_addr  in  REG_ADDR_W  destination register
i_result_src  in  3  writeback select
i_func3  in  3  access size/sign
i_mem_we  in  1  store
i_mem_re  in  1  load
i_reg_we  in  1  register write enable
o_dmem_req_valid  out  1  request valid
i_dmem_req_ready  in  1  request accepted
o_dmem_addr  out  ADDR_WIDTH  byte address
o_dmem_we  out  1  1 = store
o_dmem_wdata  out  DATA_WIDTH  lane-aligned store data
o_dmem_wstrb  out  DATA_WIDTH/8  byte strobes
i_dmem_resp_valid  in  1  load data valid
i_dmem_rdata  in  DATA_WIDTH  aligned doubleword read data
o_stall_mem  out  1  freeze upstream stages
o_rd_addr_fwd  out  REG_ADDR_W  comb i_rd_addr, for hazard unit
o_reg_we_fwd  out  1  comb i_reg_we
o_pc_plus4, o_pc_target, o_imm_ext, o_alu_result  out  per input  registered to writeback
o_read_data  out  DATA_WIDTH  registered extended load data
o_rd_addr  out  REG_ADDR_W  registered
o_result_src  out  3  registered
o_reg_we  out  1  registered

Behaviour:
- Reset: sync on i_arst at posedge i_clk. FSM goes to IDLE; every registered output is 0. Combinational outputs follow from IDLE and the current inputs.
- Access = i_mem_we | i_mem_re. If both are set, it is treated as a store.
- FSM states: IDLE and WAIT_RESP.
- IDLE, no access:
  - req_valid = 0, stall = 0.
  - Pipeline register captures the inputs; o_read_data = 0.
- IDLE, store:
  - req_valid = 1, o_dmem_we = 1.
  - stall = ~i_dmem_req_ready.
  - On handshake the pipeline register captures the inputs and the FSM stays in IDLE. Latency 0 extra cycles when ready.
- IDLE, load:
  - req_valid = 1, o_dmem_we = 0, stall = 1.
  - On handshake go to WAIT_RESP.
- WAIT_RESP:
  - req_valid = 0. stall = ~i_dmem_resp_valid.
  - On resp_valid: capture inputs plus the extended load into o_read_data, then go to IDLE.
  - Minimum load latency: 1 stall cycle (response earliest the cycle after the handshake).
- i_dmem_resp_valid is ignored in IDLE, including stray responses after a reset mid-load.
- Request stability:
  - o_dmem_addr, wdata, wstrb and we stay stable while valid & ~ready, because upstream is stalled.
  - req_valid never drops before the handshake unless reset occurs.
- Stall cycles: the pipeline register loads a bubble (o_reg_we = 0, o_result_src = 0, other fields held) so writeback sees no duplicate write.
- o_dmem_addr = i_alu_result. Lane offset: off = addr[2:0].
- Store (func3 0/1/2/3 = byte/half/word/double):
  - wdata = write_data << (8*off).
  - Base strobes 0x01, 0x03, 0x0F, 0xFF, shifted left by off and truncated to 8 bits. Misaligned bytes beyond lane 7 are dropped; there is no trap.
- Load:
  - lane = rdata >> (8*off).
  - func3 0 lb, 1 lh, 2 lw sign-extend; 3 ld passes through; 4 lbu, 5 lhu, 6 lwu zero-extend; 7 gives 0.
- Forwarding outputs are purely combinational and valid during stalls.

Decomposition:
- Package mem_stage_pkg holds:
  - FSM state enum (IDLE, WAIT_RESP).
  - func3 localparams (LB..LWU, SB..SD).
  - Strobe width constant DATA_WIDTH/8.
- Sub-module load_store_align (combinational): store wdata/strobe generation and load extraction/extension.
- Pipeline register: preg_memory, clocked with sync reset and a bubble input.

Test Plan:
- Reset mid-load: load req handshake, assert i_arst in WAIT_RESP -> next cycle FSM IDLE, req_valid = 0, all registered outputs 0; a late resp_valid is ignored.
- sb with addr 0x1005, write_data 0xAB, ready = 1 -> wdata byte5 = 0xAB, wstrb = 0x20, stall = 0, single cycle.
- sd with ready low for 3 cycles -> req_valid held with stable addr/data, stall = 1 for 3 cycles, o_reg_we = 0 bubbles, completes on cycle 4.
- lb addr 0x2003, rdata 0x0000_0000_8000_0000 (byte3 = 0x80), resp 2 cycles after handshake -> o_read_data = 0xFFFF_FFFF_FFFF_FF80, stall exactly 3 cycles total.
- lhu addr 0x2006, rdata byte7..6 = 0xBEEF -> o_read_data = 0x0000_0000_0000_BEEF; lw same data at addr 0x2004 gives sign-extended upper word.
- Non-memory ALU op with reg_we = 1, rd = 7 -> no request, stall = 0, next cycle o_rd_addr = 7, o_reg_we = 1, o_alu_result = input.
